// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks a (possibly wrapping) range of register addresses,
// reads each entry through a borrowed read port, forwards a same-cycle write-back,
// and streams {address, value, last} over a valid/ready interface.
module regfile_dump_reader #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [N-1:0]      wb_writeData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [N-1:0]      out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [N-1:0]        out_data_q;
  logic                out_last_q;
  logic [N-1:0]        fetch_data;

  // Value captured in FETCH: r0 is hard zero, a write-back to cur in the same cycle wins.
  always_comb begin
    fetch_data = rd_data;
    if (cur_q == '0) begin
      fetch_data = '0;
    end else if (wb_regWrite && (wb_rd == cur_q)) begin
      fetch_data = wb_writeData;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = first_reg;
          end_d   = last_reg;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StSend;
      StSend: begin
        if (out_ready) begin
          if (cur_q == end_q) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + 1'b1;  // wraps modulo 2**ADDR_W
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  // State and beat registers; the beat is a snapshot taken only in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      end_q      <= '0;
      rd_addr_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      if (state_q == StFetch) begin
        rd_addr_q  <= cur_q;
        out_addr_q <= cur_q;
        out_data_q <= fetch_data;
        out_last_q <= (cur_q == end_q);
      end
    end
  end

  // Read address tracks cur during FETCH and otherwise holds the last fetched address.
  always_comb begin
    rd_addr   = (state_q == StFetch) ? cur_q : rd_addr_q;
    out_valid = (state_q == StSend);
    out_addr  = out_addr_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a behavioural register file written through the
// write-back port, and a scoreboard of expected beats pushed at start time.
module tb_regfile_dump_reader;

  localparam int unsigned N = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, wb_regWrite, out_ready;
  logic [AW-1:0] first_reg, last_reg, rd_addr, wb_rd, out_addr;
  logic [N-1:0]  rd_data, wb_writeData, out_data;
  logic          out_valid, out_last, busy, done;

  logic [N-1:0]  regs  [32];
  logic [N-1:0]  model [32];
  beat_t         exp_q [$];
  beat_t         e;
  int            tests_run = 0;
  int            tests_failed = 0;

  always #5 clk = ~clk;

  // Register file: combinational read, write on posedge, r0 never written.
  assign rd_data = regs[rd_addr];
  always @(posedge clk) begin
    if (wb_regWrite && wb_rd != 0) regs[wb_rd] <= wb_writeData;
  end

  regfile_dump_reader #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_writeData(wb_writeData),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] exp_val(int a);
    return (a == 0) ? '0 : model[a];
  endfunction

  // Push the expected beats for a walk from f to l (inclusive, wrapping).
  task automatic push_range(int f, int l);
    int a = f;
    forever begin
      e.addr = AW'(a); e.data = exp_val(a); e.last = (a == l);
      exp_q.push_back(e);
      if (a == l) break;
      a = (a + 1) % 32;
    end
  endtask

  task automatic preload;
    for (int i = 1; i < 32; i++) begin
      wb_regWrite = 1'b1; wb_rd = AW'(i); wb_writeData = i * 32'h01010101;
      model[i] = i * 32'h01010101;
      tick;
    end
    wb_regWrite = 1'b0;
    model[0] = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    tests_run++;
    if ({rd_addr, out_addr, out_data, out_valid, out_last, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset: rd_addr=%0d addr=%0d data=%h v=%b l=%b busy=%b done=%b, want all 0",
               rd_addr, out_addr, out_data, out_valid, out_last, busy, done);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_full_range;
    int first_v = -1, done_c = -1;
    exp_q.delete();
    push_range(0, 31);
    first_reg = 0; last_reg = 31; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        tests_run++;
        e = exp_q.pop_front();
        if ({out_addr, out_data, out_last} !== {e.addr, e.data, e.last}) begin
          tests_failed++;
          $display("FAIL full_beat: got %0d/%h/%b want %0d/%h/%b",
                   out_addr, out_data, out_last, e.addr, e.data, e.last);
        end
      end
      if (done) begin done_c = c; break; end
      tick;
    end
    tests_run++;
    if (first_v !== 2 || done_c !== 65 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL full_timing: first_valid=%0d done=%0d left=%0d want 2/65/0",
               first_v, done_c, exp_q.size());
    end
    tick;
  endtask

  task automatic test_wrap;
    int done_c = -1;
    exp_q.delete();
    push_range(30, 1);
    first_reg = 30; last_reg = 1; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid) begin
        tests_run++;
        e = exp_q.pop_front();
        if ({out_addr, out_data, out_last} !== {e.addr, e.data, e.last}) begin
          tests_failed++;
          $display("FAIL wrap_beat: got %0d/%h/%b want %0d/%h/%b",
                   out_addr, out_data, out_last, e.addr, e.data, e.last);
        end
      end
      if (done) begin done_c = c; break; end
      tick;
    end
    tests_run++;
    if (done_c !== 9 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL wrap_done: done=%0d left=%0d want 9/0", done_c, exp_q.size());
    end
    tick;
  endtask

  task automatic test_backpressure;
    exp_q.delete();
    push_range(7, 7);
    first_reg = 7; last_reg = 7; out_ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if ({out_valid, out_addr, out_data, out_last} !== {1'b1, 5'd7, model[7], 1'b1}) begin
        tests_failed++;
        $display("FAIL hold_beat: got v=%b %0d/%h/%b want v=1 7/%h/1",
                 out_valid, out_addr, out_data, out_last, model[7]);
      end
      tick;
    end
    out_ready = 1'b1;
    tests_run++;
    e = exp_q.pop_front();
    if ({out_valid, out_addr, out_data} !== {1'b1, e.addr, e.data}) begin
      tests_failed++;
      $display("FAIL release_beat: got v=%b %0d/%h want v=1 %0d/%h",
               out_valid, out_addr, out_data, e.addr, e.data);
    end
    tick;
    tests_run++;
    if ({done, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL release_done: done=%b valid=%b want 1/0", done, out_valid);
    end
    tick;
  endtask

  task automatic test_forward;
    // Write-back to r5 in its FETCH cycle is forwarded.
    exp_q.delete();
    first_reg = 5; last_reg = 5; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tests_run++;
    if (rd_addr !== 5'd5) begin
      tests_failed++;
      $display("FAIL fetch_rd_addr: got %0d want 5", rd_addr);
    end
    wb_regWrite = 1'b1; wb_rd = 5; wb_writeData = 32'hDEADBEEF;
    model[5] = 32'hDEADBEEF;
    push_range(5, 5);
    tick;
    wb_regWrite = 1'b0;
    tests_run++;
    e = exp_q.pop_front();
    if ({out_valid, out_data} !== {1'b1, e.data}) begin
      tests_failed++;
      $display("FAIL fwd_fetch: got v=%b %h want v=1 %h", out_valid, out_data, e.data);
    end
    tick; tick;
    // Write during SEND must not disturb the held snapshot.
    out_ready = 1'b0; start = 1'b1;
    push_range(5, 5);
    tick;
    start = 1'b0;
    tick;
    wb_regWrite = 1'b1; wb_rd = 5; wb_writeData = 32'h12345678;
    tick;
    wb_regWrite = 1'b0;
    model[5] = 32'h12345678;
    out_ready = 1'b1;
    tests_run++;
    e = exp_q.pop_front();
    if ({out_valid, out_data} !== {1'b1, e.data}) begin
      tests_failed++;
      $display("FAIL snapshot_send: got v=%b %h want v=1 %h", out_valid, out_data, e.data);
    end
    tick; tick;
    // Write to r0 in FETCH of r0 still yields zero.
    first_reg = 0; last_reg = 0; start = 1'b1;
    push_range(0, 0);
    tick;
    start = 1'b0;
    wb_regWrite = 1'b1; wb_rd = 0; wb_writeData = 32'hFFFFFFFF;
    tick;
    wb_regWrite = 1'b0;
    tests_run++;
    e = exp_q.pop_front();
    if ({out_valid, out_addr, out_data} !== {1'b1, e.addr, e.data}) begin
      tests_failed++;
      $display("FAIL r0_forward: got v=%b %0d/%h want v=1 0/%h",
               out_valid, out_addr, out_data, e.data);
    end
    tick; tick;
  endtask

  task automatic test_abort_and_rst;
    int done_seen = 0, done_c = -1;
    // Abort in IDLE with start: stays idle.
    abort = 1'b1; start = 1'b1; first_reg = 0; last_reg = 31;
    tick;
    abort = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: busy=%b want 0", busy);
    end
    exp_q.delete();
    push_range(0, 31);
    out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_addr == 10) break;
      if (out_valid) begin
        tests_run++;
        e = exp_q.pop_front();
        if ({out_addr, out_data} !== {e.addr, e.data}) begin
          tests_failed++;
          $display("FAIL pre_abort_beat: got %0d/%h want %0d/%h",
                   out_addr, out_data, e.addr, e.data);
        end
      end
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (done || busy || out_valid) done_seen++;
      tick;
    end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL abort_idle_after: active cycles=%0d want 0", done_seen);
    end
    // Fresh dump after abort.
    push_range(3, 4);
    first_reg = 3; last_reg = 4; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        tests_run++;
        e = exp_q.pop_front();
        if ({out_addr, out_data, out_last} !== {e.addr, e.data, e.last}) begin
          tests_failed++;
          $display("FAIL post_abort_beat: got %0d/%h/%b want %0d/%h/%b",
                   out_addr, out_data, out_last, e.addr, e.data, e.last);
        end
      end
      if (done) begin done_c = c; break; end
      tick;
    end
    tests_run++;
    if (done_c !== 5) begin
      tests_failed++;
      $display("FAIL post_abort_done: done=%0d want 5", done_c);
    end
    tick;
    // Reset mid-dump.
    first_reg = 0; last_reg = 31; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests_run++;
    if ({rd_addr, out_addr, out_data, out_valid, out_last, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid: rd_addr=%0d addr=%0d data=%h v=%b l=%b busy=%b done=%b want 0",
               rd_addr, out_addr, out_data, out_valid, out_last, busy, done);
    end
    tick;
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    exp_q.delete();
    push_range(2, 4);
    first_reg = 2; last_reg = 4; out_ready = 1'b1; start = 1'b1;
    tick;
    first_reg = 20; last_reg = 25;
    for (int c = 1; c <= 30; c++) begin
      if (out_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL busy_extra_beat: got %0d want none", out_addr);
        end else begin
          e = exp_q.pop_front();
          if ({out_addr, out_data, out_last} !== {e.addr, e.data, e.last}) begin
            tests_failed++;
            $display("FAIL busy_beat: got %0d/%h/%b want %0d/%h/%b",
                     out_addr, out_data, out_last, e.addr, e.data, e.last);
          end
        end
      end
      if (done) begin dones++; start = 1'b0; end
      tick;
    end
    start = 1'b0;
    tests_run++;
    if (dones !== 1 || exp_q.size() !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start: dones=%0d left=%0d busy=%b want 1/0/0",
               dones, exp_q.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; first_reg = '0; last_reg = '0;
    wb_regWrite = 1'b0; wb_rd = '0; wb_writeData = '0; out_ready = 1'b0;
    test_reset;
    preload;
    test_full_range;
    test_wrap;
    test_backpressure;
    test_forward;
    test_abort_and_rst;
    test_start_while_busy;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
